// File: rtl/tinyalu_pkg.sv
// ============================================================================
// Module      : tinyalu_pkg
// Description : Shared ALU593 opcode type and arbiter constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tinyalu_pkg;

  typedef enum logic [2:0] {
    op_nop  = 3'd0,
    op_add  = 3'd1,
    op_and  = 3'd2,
    op_xor  = 3'd3,
    op_mul  = 3'd4,
    op_sp0  = 3'd5,
    op_res1 = 3'd6,
    op_res2 = 3'd7
  } alu_opcode_t;

  localparam int unsigned ARB_TIMEOUT_DEFAULT = 15;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module      : rr_arbiter_2
// Description : Two-way round-robin grant; on a tie the requester that did
//               not win last time is chosen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/alu593_arbiter.sv
// ============================================================================
// Module      : alu593_arbiter
// Description : Arbitrates two requesters onto one ALU593, with a BUSY
//               timeout and a registered one-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu593_arbiter
  import tinyalu_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_A0,
  input  logic [7:0]  req_B0,
  input  logic [7:0]  req_A1,
  input  logic [7:0]  req_B1,
  input  alu_opcode_t req_op0,
  input  alu_opcode_t req_op1,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output alu_opcode_t alu_op,
  output logic        alu_start,
  input  logic [15:0] alu_result,
  input  logic        alu_done,
  input  logic        alu_error,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [15:0] resp_result,
  output logic        resp_error
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Counter value seen on the last permitted BUSY cycle.
  localparam logic [7:0] c_TCNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  w_grant;
  logic        w_accept;
  logic        w_finish;
  logic        w_timeout;
  logic        r_last_grant;
  logic [7:0]  r_tcnt;
  logic [7:0]  r_hold_A;
  logic [7:0]  r_hold_B;
  alu_opcode_t r_hold_op;
  logic        r_hold_id;
  logic        r_resp_valid;
  logic        r_resp_id;
  logic [15:0] r_resp_result;
  logic        r_resp_error;

  rr_arbiter_2 u_rr_arbiter_2 (
    .valid      (req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant)
  );

  assign w_timeout = (r_state == S_BUSY) && !alu_done && (r_tcnt == c_TCNT_LAST);

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_grant) begin
          w_accept     = 1'b1;
          w_next_state = S_BUSY;
        end
      end
      S_BUSY: begin
        if (alu_done || w_timeout) begin
          w_finish     = 1'b1;
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant  <= 1'b1;
      r_tcnt        <= 8'd0;
      r_hold_A      <= 8'd0;
      r_hold_B      <= 8'd0;
      r_hold_op     <= op_nop;
      r_hold_id     <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_id     <= 1'b0;
      r_resp_result <= 16'd0;
      r_resp_error  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      if (w_accept) begin
        r_last_grant <= w_grant[1];
        r_hold_id    <= w_grant[1];
        r_hold_A     <= w_grant[1] ? req_A1  : req_A0;
        r_hold_B     <= w_grant[1] ? req_B1  : req_B0;
        r_hold_op    <= w_grant[1] ? req_op1 : req_op0;
        r_tcnt       <= 8'd0;
      end else if (r_state == S_BUSY) begin
        r_tcnt <= r_tcnt + 8'd1;
      end
      // A done in the timeout cycle still returns the ALU's own result.
      if (w_finish) begin
        r_resp_valid  <= 1'b1;
        r_resp_id     <= r_hold_id;
        r_resp_result <= alu_done ? alu_result : 16'd0;
        r_resp_error  <= alu_done ? alu_error  : 1'b1;
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE && !reset) ? w_grant : 2'b00;
  assign alu_start   = (r_state == S_BUSY);
  assign alu_A       = r_hold_A;
  assign alu_B       = r_hold_B;
  assign alu_op      = r_hold_op;
  assign resp_valid  = r_resp_valid;
  assign resp_id     = r_resp_id;
  assign resp_result = r_resp_result;
  assign resp_error  = r_resp_error;

endmodule

`default_nettype wire

// File: tb/tb_alu593_arbiter.sv
// ============================================================================
// Module      : tb_alu593_arbiter
// Description : Randomized self-checking bench with a transaction-level
//               reference model and a behavioural ALU593 responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu593_arbiter;
  import tinyalu_pkg::*;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_A0, req_B0, req_A1, req_B1;
  alu_opcode_t req_op0, req_op1;
  logic [7:0]  alu_A, alu_B;
  alu_opcode_t alu_op;
  logic        alu_start;
  logic [15:0] alu_result;
  logic        alu_done;
  logic        alu_error;
  logic        resp_valid;
  logic        resp_id;
  logic [15:0] resp_result;
  logic        resp_error;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, tracked per transaction in absolute cycle numbers.
  int          cyc;
  int          free_at;
  int          resp_at;
  int          busy_lo;
  int          busy_hi;
  logic        m_last;
  logic [7:0]  m_A, m_B;
  alu_opcode_t m_op;
  logic        p_id, p_err;
  logic [15:0] p_res;
  logic        r_id, r_err;
  logic [15:0] r_res;
  int          lat_cur;
  int          busy_cyc;

  always #5 clk = ~clk;

  alu593_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_A0      (req_A0),
    .req_B0      (req_B0),
    .req_A1      (req_A1),
    .req_B1      (req_B1),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .alu_A       (alu_A),
    .alu_B       (alu_B),
    .alu_op      (alu_op),
    .alu_start   (alu_start),
    .alu_result  (alu_result),
    .alu_done    (alu_done),
    .alu_error   (alu_error),
    .resp_valid  (resp_valid),
    .resp_id     (resp_id),
    .resp_result (resp_result),
    .resp_error  (resp_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // ALU593 behaviour: {error, result}
  function automatic logic [16:0] alu_fn(input alu_opcode_t op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      op_add:           return {1'b0, 16'(a) + 16'(b)};
      op_and:           return {1'b0, 16'(a & b)};
      op_xor:           return {1'b0, 16'(a ^ b)};
      op_mul:           return {1'b0, 16'(a) * 16'(b)};
      op_sp0:           return {1'b0, 16'(a) * (16'(b) + 16'd1)};
      op_res1, op_res2: return {1'b1, 16'h0000};
      default:          return 17'h0;
    endcase
  endfunction

  task automatic model_reset();
    free_at  = 0;
    resp_at  = -1;
    busy_lo  = 0;
    busy_hi  = -1;
    m_last   = 1'b1;
    m_A      = 8'd0;
    m_B      = 8'd0;
    m_op     = op_nop;
    r_id     = 1'b0;
    r_err    = 1'b0;
    r_res    = 16'd0;
    lat_cur  = 0;
    busy_cyc = 0;
  endtask

  // One clock cycle: drive ALU responder and requests, then check everything.
  task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] b0,
                      input logic [7:0] a1, input logic [7:0] b1,
                      input alu_opcode_t o0, input alu_opcode_t o1, input int lat_next);
    logic [1:0]  exp_ready;
    logic [16:0] er;
    @(negedge clk);
    cyc++;
    if (alu_start) busy_cyc++;
    else           busy_cyc = 0;
    {alu_error, alu_result} = alu_fn(alu_op, alu_A, alu_B);
    alu_done  = alu_start && (lat_cur != 0) && (busy_cyc == lat_cur);
    req_valid = v;
    req_A0 = a0; req_B0 = b0; req_op0 = o0;
    req_A1 = a1; req_B1 = b1; req_op1 = o1;
    #1;
    exp_ready = 2'b00;
    if (cyc >= free_at) begin
      case (v)
        2'b01:   exp_ready = 2'b01;
        2'b10:   exp_ready = 2'b10;
        2'b11:   exp_ready = m_last ? 2'b01 : 2'b10;
        default: exp_ready = 2'b00;
      endcase
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    check_eq("alu_start", 32'(alu_start), (cyc >= busy_lo && cyc <= busy_hi) ? 32'd1 : 32'd0);
    check_eq("alu_A", 32'(alu_A), 32'(m_A));
    check_eq("alu_B", 32'(alu_B), 32'(m_B));
    check_eq("alu_op", 32'(alu_op), 32'(m_op));
    if (cyc == resp_at) begin
      r_id  = p_id;
      r_res = p_res;
      r_err = p_err;
    end
    check_eq("resp_valid", 32'(resp_valid), (cyc == resp_at) ? 32'd1 : 32'd0);
    check_eq("resp_id", 32'(resp_id), 32'(r_id));
    check_eq("resp_result", 32'(resp_result), 32'(r_res));
    check_eq("resp_error", 32'(resp_error), 32'(r_err));
    if (exp_ready != 2'b00) begin
      p_id   = exp_ready[1];
      m_last = p_id;
      m_A    = p_id ? a1 : a0;
      m_B    = p_id ? b1 : b0;
      m_op   = p_id ? o1 : o0;
      er     = alu_fn(m_op, m_A, m_B);
      if (lat_next != 0 && lat_next <= TIMEOUT) begin
        resp_at = cyc + lat_next + 1;
        p_err   = er[16];
        p_res   = er[15:0];
      end else begin
        resp_at = cyc + TIMEOUT + 1;
        p_err   = 1'b1;
        p_res   = 16'd0;
      end
      busy_lo = cyc + 1;
      busy_hi = resp_at - 1;
      free_at = resp_at + 1;
      lat_cur = lat_next;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 8'd0, 8'd0, 8'd0, 8'd0, op_nop, op_nop, 1);
  endtask

  // Reset may land mid-transaction; outputs must drop in the same cycle.
  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 2'b11;
    alu_done  = 1'b0;
    #1;
    check_eq("rst_alu_start", 32'(alu_start), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check_eq("rst_alu_A", 32'(alu_A), 32'd0);
    check_eq("rst_alu_B", 32'(alu_B), 32'd0);
    check_eq("rst_alu_op", 32'(alu_op), 32'(op_nop));
    check_eq("rst_resp_id", 32'(resp_id), 32'd0);
    check_eq("rst_resp_result", 32'(resp_result), 32'd0);
    check_eq("rst_resp_error", 32'(resp_error), 32'd0);
    reset     = 1'b0;
    req_valid = 2'b00;
    model_reset();
  endtask

  initial begin
    int r, lat;
    reset      = 1'b1;
    req_valid  = 2'b00;
    req_A0 = 8'd0; req_B0 = 8'd0; req_A1 = 8'd0; req_B1 = 8'd0;
    req_op0    = op_nop;
    req_op1    = op_nop;
    alu_result = 16'd0;
    alu_done   = 1'b0;
    alu_error  = 1'b0;
    cyc        = 0;
    p_id = 1'b0; p_err = 1'b0; p_res = 16'd0;
    model_reset();
    do_reset();

    // Both requesters held valid: grants alternate 0,1,0 from reset.
    for (int i = 0; i < 9; i++) step(2'b11, 8'd3, 8'd4, 8'hF0, 8'h0F, op_mul, op_xor, 1);
    idle(3);
    // Single requester 0 add.
    step(2'b01, 8'h05, 8'h03, 8'h00, 8'h00, op_add, op_nop, 1);
    idle(3);
    // Requester 1 special op with multi-cycle ALU latency.
    step(2'b10, 8'h00, 8'h00, 8'd2, 8'd5, op_nop, op_sp0, 3);
    idle(5);
    // Reserved opcode reports an error.
    step(2'b01, 8'h07, 8'h09, 8'h00, 8'h00, op_res1, op_nop, 2);
    idle(4);
    // ALU never finishes: timeout response.
    step(2'b01, 8'h11, 8'h22, 8'h00, 8'h00, op_add, op_nop, 0);
    idle(TIMEOUT + 3);
    // Done coincides with the last permitted BUSY cycle.
    step(2'b10, 8'h00, 8'h00, 8'h40, 8'h02, op_nop, op_mul, TIMEOUT);
    idle(TIMEOUT + 3);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14)      lat = 1 + (r % 4);
      else if (r < 16) lat = TIMEOUT;
      else if (r < 18) lat = 0;
      else             lat = TIMEOUT - 1;
      step(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           alu_opcode_t'($urandom_range(0, 7)), alu_opcode_t'($urandom_range(0, 7)), lat);
    end
    idle(TIMEOUT + 3);

    // Reset during BUSY of a multiply, then a fresh grant.
    step(2'b01, 8'd3, 8'd4, 8'd0, 8'd0, op_mul, op_nop, 0);
    idle(3);
    do_reset();
    idle(2);
    step(2'b10, 8'd0, 8'd0, 8'd6, 8'd7, op_nop, op_mul, 1);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu593_arbiter.md
ALU593_ARBITER -- requirements
Module: alu593_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum cycles in BUSY waiting for alu_done (legal range 1..255).
REQ-002 clk  in  1  sole clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  2  per-requester request pending; index 0 and 1.
REQ-005 req_ready  out  2  one-hot pulse; request accepted this cycle.
REQ-006 req_A0, req_B0, req_A1, req_B1  in  8 each  operands per requester.
REQ-007 req_op0, req_op1  in  alu_opcode_t  opcode per requester.
REQ-008 alu_A, alu_B  out  8 each  operands to ALU593.
REQ-009 alu_op  out  alu_opcode_t  opcode to ALU593.
REQ-010 alu_start  out  1  ALU start, level-held.
REQ-011 alu_result  in  16; alu_done  in  1; alu_error  in  1  ALU593 outputs.
REQ-012 resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-013 resp_id  out  1  requester index of response.
REQ-014 resp_result  out  16; resp_error  out  1  returned result and error flag.

Function
REQ-015 FSM states IDLE, BUSY, DRAIN; reset state IDLE.
REQ-016 IDLE: if any req_valid, grant one requester, assert its req_ready combinationally, capture its A/B/op and index into hold registers, go BUSY at next edge.
REQ-017 Grant: single valid wins; both valid -> requester other than last_grant wins; last_grant updated on every grant.
REQ-018 BUSY: alu_start=1, alu_A/alu_B/alu_op driven from hold registers, stable for entire BUSY.
REQ-019 BUSY with alu_done=1: register alu_result, alu_error, held id into resp_*; resp_valid=1 next cycle; go DRAIN.
REQ-020 BUSY timeout counter: cleared entering BUSY, +1 each BUSY cycle; alu_done low after TIMEOUT cycles in BUSY -> resp_valid=1, resp_error=1, resp_result=0, go DRAIN.
REQ-021 alu_done and timeout in same cycle: alu_done wins, no timeout error.
REQ-022 DRAIN: alu_start=0 for exactly one cycle, no grant, then IDLE.
REQ-023 Outside BUSY: alu_start=0; alu_A/alu_B/alu_op hold last values.
REQ-024 req_ready asserted only in IDLE, at most one bit, only for a valid requester.
REQ-025 Minimum throughput: one request per 3 cycles when ALU returns done on first BUSY cycle.
REQ-026 resp_valid pulses exactly once per accepted request; resp_* hold values until next response.
REQ-027 Requests deasserting before grant are dropped silently; no internal request queue.

Reset
REQ-028 Reset assertion mid-operation aborts immediately: state IDLE, alu_start=0, resp_valid=0, req_ready=0, no pending response.
REQ-029 Reset values: alu_A=0, alu_B=0, alu_op=op_nop, resp_id=0, resp_result=0, resp_error=0, timeout counter=0, last_grant=1 (requester 0 wins first tie).
REQ-030 First grant possible in first cycle after reset deassertion.

Structure
REQ-031 alu_opcode_t from tinyalu_pkg; ARB_TIMEOUT_DEFAULT constant added to tinyalu_pkg; FSM state enum local.
REQ-032 Grant logic in sub-module rr_arbiter_2 (inputs valid[1:0], last_grant; output one-hot grant).

Verification
REQ-033 Req0 op_add A=8'h05 B=8'h03 -> req_ready=2'b01, ALU op_add held, resp_id=0, resp_result=16'h0008, resp_error=0.
REQ-034 Both valid continuously, req0 op_mul 3x4, req1 op_xor 8'hF0^8'h0F -> grants alternate 0,1,0; responses 16'h000C then 16'h00FF.
REQ-035 Req1 op_sp0 A=2 B=5 -> alu_start held until done, resp_result=16'h000C, resp_id=1.
REQ-036 Req0 op_res1 -> resp_error=1, one resp_valid pulse, back in IDLE after DRAIN.
REQ-037 ALU model never asserts done, TIMEOUT=15 -> resp_valid on BUSY cycle 16 with resp_error=1, resp_result=0.
REQ-038 Reset asserted during BUSY of op_mul -> alu_start=0 same cycle, no resp_valid afterward, new request granted after release.
